// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rom_arbiter
//  Purpose  : Two-port round-robin arbiter in front of an asynchronous ROM.
//             Each accepted request drives rom_sel/rom_a for WAIT_STATES+1
//             cycles, captures rom_dout on the last of those edges, then
//             presents a one-cycle response pulse to the requester that owns
//             the access. Only one access is in flight at a time.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WAIT_STATES  extra cycles the ROM address is held before sampling (0..15)
//    ADDR_W       ROM address width
//  Ports
//    clk          single clock, rising edge
//    rst          asynchronous, active-high reset
//    req0_valid   requester 0 (CPU fetch) wants an access
//    req0_addr    requester 0 address
//    req0_ready   requester 0 accepted this cycle (combinational)
//    rsp0_valid   one-cycle pulse: rsp_data holds requester 0 read data
//    req1_valid   requester 1 (debug/loader) wants an access
//    req1_addr    requester 1 address
//    req1_ready   requester 1 accepted this cycle (combinational)
//    rsp1_valid   one-cycle pulse: rsp_data holds requester 1 read data
//    rsp_data     shared read data, held until the next capture
//    rom_sel      ROM chip select, high only while an access is in progress
//    rom_a        ROM address
//    rom_dout     ROM read data, combinational from rom_a
// ============================================================================
module rom_arbiter #(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic              rsp0_valid,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [7:0]        rsp_data,
    output logic              rom_sel,
    output logic [ADDR_W-1:0] rom_a,
    input  logic [7:0]        rom_dout
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The wait-state counter only needs to cover 0..15.
    localparam int               c_cnt_w   = 4;
    localparam logic [c_cnt_w-1:0] c_wait  = c_cnt_w'(WAIT_STATES);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_access  = 2'd1;
    localparam logic [1:0] c_respond = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]         state_q,      state_d;
    logic [c_cnt_w-1:0] cnt_q,        cnt_d;
    logic [ADDR_W-1:0]  addr_q,       addr_d;
    logic               owner_q,      owner_d;
    logic               last_grant_q, last_grant_d;
    logic [7:0]         rsp_data_q,   rsp_data_d;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    // w_pick1 names the requester that would win if a handshake happened now.
    // With a single requester it simply follows req1_valid; under contention
    // the requester that did not win last time gets the slot.
    logic w_pick1;
    logic w_idle;
    logic w_accept;

    always_comb begin
        w_pick1 = 1'b0;
        if (req0_valid && req1_valid) begin
            w_pick1 = ~last_grant_q;
        end else begin
            w_pick1 = req1_valid;
        end
    end

    assign w_idle     = (state_q == c_idle);

    // Ready is only offered in IDLE, so requests seen during ACCESS or
    // RESPOND leave no trace. At most one of the two can be high because
    // each is qualified by the opposite polarity of w_pick1.
    assign req0_ready = w_idle & req0_valid & ~w_pick1;
    assign req1_ready = w_idle & req1_valid &  w_pick1;
    assign w_accept   = req0_ready | req1_ready;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        rsp_data_d   = rsp_data_q;

        case (state_q)
            c_idle: begin
                if (w_accept) begin
                    // The address is copied here so the requester is free
                    // to change it while the access is in flight.
                    addr_d       = w_pick1 ? req1_addr : req0_addr;
                    owner_d      = w_pick1;
                    last_grant_d = w_pick1;
                    cnt_d        = c_wait;
                    state_d      = c_access;
                end
            end

            c_access: begin
                if (cnt_q == '0) begin
                    rsp_data_d = rom_dout;
                    state_d    = c_respond;
                end else begin
                    cnt_d = cnt_q - c_cnt_one;
                end
            end

            c_respond: begin
                state_d = c_idle;
            end

            default: begin
                state_d = c_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // last_grant resets to requester 1 so that requester 0 wins the first
    // contention after reset. Resetting state_q also kills any access in
    // flight, so no late response can appear after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= c_idle;
            cnt_q        <= '0;
            addr_q       <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_data_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // All outputs decode directly from registered state, so the asynchronous
    // reset clears them in the same instant it clears the flops.
    assign rom_sel    = (state_q == c_access);
    assign rom_a      = addr_q;
    assign rsp0_valid = (state_q == c_respond) & ~owner_q;
    assign rsp1_valid = (state_q == c_respond) &  owner_q;
    assign rsp_data   = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom_arbiter
//  Purpose  : Self-checking bench for rom_arbiter. Two instances are built,
//             one with WAIT_STATES=1 (index 0) and one with WAIT_STATES=0
//             (index 1). A transaction-level model predicts grants, the
//             chip-select window and the response (port, byte, cycle); a
//             negedge monitor compares the DUT outputs against it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rom_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst;
    logic [1:0]      v0, v1;
    logic [1:0][3:0] a0, a1;
    wire  [1:0]      rdy0, rdy1, rsp0, rsp1, sel;
    wire  [1:0][3:0] rom_a;
    wire  [1:0][7:0] rsp_data;
    wire  [1:0][7:0] rom_dout;

    // Boot ROM image; unnamed locations get an address-derived pattern.
    function automatic logic [7:0] rom_img(input logic [3:0] a);
        case (a)
            4'h0:    return 8'h4F;
            4'h1:    return 8'h4C;
            4'hE:    return 8'hFF;
            4'hF:    return 8'hF0;
            default: return {a, ~a} ^ 8'h35;
        endcase
    endfunction

    assign rom_dout[0] = rom_img(rom_a[0]);
    assign rom_dout[1] = rom_img(rom_a[1]);

    rom_arbiter #(.WAIT_STATES(1), .ADDR_W(4)) u_dut_ws1 (
        .clk(clk), .rst(rst[0]),
        .req0_valid(v0[0]), .req0_addr(a0[0]), .req0_ready(rdy0[0]), .rsp0_valid(rsp0[0]),
        .req1_valid(v1[0]), .req1_addr(a1[0]), .req1_ready(rdy1[0]), .rsp1_valid(rsp1[0]),
        .rsp_data(rsp_data[0]), .rom_sel(sel[0]), .rom_a(rom_a[0]), .rom_dout(rom_dout[0])
    );

    rom_arbiter #(.WAIT_STATES(0), .ADDR_W(4)) u_dut_ws0 (
        .clk(clk), .rst(rst[1]),
        .req0_valid(v0[1]), .req0_addr(a0[1]), .req0_ready(rdy0[1]), .rsp0_valid(rsp0[1]),
        .req1_valid(v1[1]), .req1_addr(a1[1]), .req1_ready(rdy1[1]), .rsp1_valid(rsp1[1]),
        .rsp_data(rsp_data[1]), .rom_sel(sel[1]), .rom_a(rom_a[1]), .rom_dout(rom_dout[1])
    );

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    typedef struct {
        logic       port;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         lg[2];        // last winner
    int         free_at[2];   // first edge at which a new request can be taken
    int         acc_e[2];     // edge of the latest acceptance
    logic [3:0] acc_addr[2];
    logic [7:0] last_data[2];
    logic       exp_r0[2];
    logic       exp_r1[2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ws(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got 0x%0h expected 0x%0h", name, d, cyc, act, exp);
        end
    endtask

    task automatic model_reset(input int d);
        lg[d]        = 1;
        free_at[d]   = 0;
        acc_e[d]     = -100;
        acc_addr[d]  = 4'h0;
        last_data[d] = 8'h00;
        exp_r0[d]    = 1'b0;
        exp_r1[d]    = 1'b0;
        if (d == 0) q0.delete(); else q1.delete();
    endtask

    // Predicts what happens at the coming rising edge given the inputs now
    // being driven: at most one acceptance every WAIT_STATES+3 edges, the
    // response WAIT_STATES+1 cycles after the accepting edge.
    task automatic model_eval(input int d);
        int   e;
        logic win;
        exp_t it;
        e         = cyc + 1;
        exp_r0[d] = 1'b0;
        exp_r1[d] = 1'b0;
        if (rst[d]) return;
        if (e >= free_at[d] && (v0[d] || v1[d])) begin
            if (v0[d] && v1[d]) win = (lg[d] == 0);
            else                win = v1[d];
            if (win) exp_r1[d] = 1'b1; else exp_r0[d] = 1'b1;
            lg[d]       = win ? 1 : 0;
            acc_e[d]    = e;
            acc_addr[d] = win ? a1[d] : a0[d];
            free_at[d]  = e + ws(d) + 3;
            it.port     = win;
            it.data     = rom_img(acc_addr[d]);
            it.cyc      = e + ws(d) + 1;
            if (d == 0) q0.push_back(it); else q1.push_back(it);
        end
    endtask

    task automatic tick();
        model_eval(0);
        model_eval(1);
        @(posedge clk);
        #1;
    endtask

    task automatic rst_on(input int d);
        v0[d] = 1'b0;
        v1[d] = 1'b0;
        #1 rst[d] = 1'b1;
        #1;
        chk("rst_rom_sel",  d, sel[d],      0);
        chk("rst_rom_a",    d, rom_a[d],    0);
        chk("rst_rsp_data", d, rsp_data[d], 8'h00);
        chk("rst_rsp0",     d, rsp0[d],     0);
        chk("rst_rsp1",     d, rsp1[d],     0);
        model_reset(d);
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    task automatic mon(input int d);
        exp_t it;
        logic got;
        logic exp_rsp;
        logic exp_sel;
        got     = rsp0[d] | rsp1[d];
        exp_rsp = 1'b0;
        if (d == 0) begin
            while (q0.size() > 0 && q0[0].cyc < cyc) void'(q0.pop_front());
            if (q0.size() > 0 && q0[0].cyc == cyc) begin
                exp_rsp = 1'b1;
                it      = q0.pop_front();
            end
        end else begin
            while (q1.size() > 0 && q1[0].cyc < cyc) void'(q1.pop_front());
            if (q1.size() > 0 && q1[0].cyc == cyc) begin
                exp_rsp = 1'b1;
                it      = q1.pop_front();
            end
        end
        chk("rsp_valid",    d, got,               exp_rsp);
        chk("req0_ready",   d, rdy0[d],           exp_r0[d]);
        chk("req1_ready",   d, rdy1[d],           exp_r1[d]);
        chk("both_ready",   d, rdy0[d] & rdy1[d], 0);
        chk("both_rsp",     d, rsp0[d] & rsp1[d], 0);
        exp_sel = (cyc >= acc_e[d]) && (cyc <= acc_e[d] + ws(d));
        chk("rom_sel",      d, sel[d],            exp_sel);
        if (exp_sel) chk("rom_a", d, rom_a[d], acc_addr[d]);
        if (exp_rsp) begin
            chk("rsp_port", d, rsp1[d], it.port);
            last_data[d] = it.data;
        end
        chk("rsp_data",     d, rsp_data[d],       last_data[d]);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst[d]) mon(d);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        rst = 2'b11;
        v0  = '0;
        v1  = '0;
        a0  = '0;
        a1  = '0;
        model_reset(0);
        model_reset(1);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("init_rom_sel",  d, sel[d],      0);
            chk("init_rom_a",    d, rom_a[d],    0);
            chk("init_rsp_data", d, rsp_data[d], 8'h00);
            chk("init_rsp",      d, rsp0[d] | rsp1[d], 0);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 2'b00;

        // Single read on each instance: req0 0x0 (1 wait), req1 0xF (0 wait).
        v0[0] = 1'b1; a0[0] = 4'h0;
        v1[1] = 1'b1; a1[1] = 4'hF;
        tick();
        v0[0] = 1'b0; v1[1] = 1'b0;
        repeat (6) tick();

        // Contention straight after reset, both held high: 0, 1, 0.
        rst_on(0);
        tick();
        rst[0] = 1'b0;
        v0[0] = 1'b1; a0[0] = 4'h1;
        v1[0] = 1'b1; a1[0] = 4'hE;
        repeat (12) tick();
        v0[0] = 1'b0; v1[0] = 1'b0;
        repeat (4) tick();

        // Address changes after acceptance; valid kept high during the access.
        v0[0] = 1'b1; a0[0] = 4'h0;
        tick();
        a0[0] = 4'hE;
        repeat (3) tick();
        v0[0] = 1'b0;
        repeat (6) tick();

        // Reset in the second ACCESS cycle, then contention goes to req0.
        v0[0] = 1'b1; a0[0] = 4'h0;
        tick();
        v0[0] = 1'b0;
        tick();
        rst_on(0);
        repeat (2) tick();
        rst[0] = 1'b0;
        repeat (6) tick();
        v0[0] = 1'b1; a0[0] = 4'h1;
        v1[0] = 1'b1; a1[0] = 4'hE;
        tick();
        v0[0] = 1'b0; v1[0] = 1'b0;
        repeat (6) tick();

        // Random traffic on both instances.
        for (int i = 0; i < 600; i++) begin
            for (int d = 0; d < 2; d++) begin
                v0[d] = ($urandom_range(0, 9) < 6);
                v1[d] = ($urandom_range(0, 9) < 6);
                a0[d] = 4'($urandom_range(0, 15));
                a1[d] = 4'($urandom_range(0, 15));
            end
            tick();
        end
        v0 = '0;
        v1 = '0;
        repeat (10) tick();

        chk("pending_rsp", 0, q0.size(), 0);
        chk("pending_rsp", 1, q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter WAIT_STATES, default 1: extra cycles rom_sel and rom_a are held before rom_dout is sampled; legal range 0..15.
REQ-002 Parameter ADDR_W, default 4: ROM address width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req0_valid  input  1  requester 0 (CPU fetch) wants an access.
REQ-006 req0_addr  input  ADDR_W  requester 0 address.
REQ-007 req0_ready  output  1  requester 0 request accepted this cycle.
REQ-008 rsp0_valid  output  1  one-cycle pulse: rsp_data holds requester 0 read data.
REQ-009 req1_valid, req1_addr, req1_ready, rsp1_valid: same widths and meaning for requester 1 (debug/loader port).
REQ-010 rsp_data  output  8  read data, shared by both requesters.
REQ-011 rom_sel  output  1  chip select to the async ROM.
REQ-012 rom_a  output  ADDR_W  ROM address.
REQ-013 rom_dout  input  8  ROM read data, combinational from rom_a.

Function
REQ-014 FSM states are IDLE, ACCESS and RESPOND; reset state is IDLE.
REQ-015 IDLE: reqN_ready is asserted combinationally only for the granted requester, and only when that requester's valid is high; the other ready is 0.
REQ-016 Grant rule: if only one valid is high, that requester wins; if both are high, the requester not named in last_grant wins (round-robin).
REQ-017 Handshake: a rising edge with valid&ready latches addr into addr_q, the winner into owner and last_grant, loads cnt=WAIT_STATES, and moves to ACCESS.
REQ-018 ACCESS: rom_sel=1 and rom_a=addr_q; if cnt==0, the edge captures rom_dout into rsp_data and moves to RESPOND; otherwise cnt decrements.
REQ-019 RESPOND: rsp<owner>_valid=1 for exactly one cycle; the next state is IDLE; no request is accepted in this cycle.
REQ-020 Outside ACCESS: rom_sel=0 and rom_a=addr_q.
REQ-021 Latency: rspN_valid is high in the cycle WAIT_STATES+2 cycles after the accepting edge; peak throughput is one access per WAIT_STATES+3 cycles.
REQ-022 Responses carry no backpressure; the requester must consume the response in its rsp_valid cycle.
REQ-023 rsp_data holds its value until the next capture.
REQ-024 If valid drops before a handshake, there is no side effect; valid changes during ACCESS or RESPOND are ignored.
REQ-025 The requester's addr may change after acceptance without affecting the access in flight.
REQ-026 Never both readys high; never both rsp_valids high.

Reset
REQ-027 Asserting rst at any time, including mid-ACCESS, immediately forces the following:
- state=IDLE, rom_sel=0, cnt=0, addr_q=0, rom_a=0;
- rsp_data=0x00, both rsp_valid=0;
- last_grant=1, so requester 0 wins the first contention.
REQ-028 An aborted access produces no response after reset is released.

Verification (boot ROM image: 0x0->0x4F, 0x1->0x4C, 0xE->0xFF, 0xF->0xF0)
REQ-029 WAIT_STATES=1; req0 addr 0x0 accepted at edge T -> rom_sel high for cycles T+1..T+2; rsp0_valid high in cycle T+3; rsp_data=0x4F; rsp1_valid stays 0.
REQ-030 Both requesters valid after reset, req0 addr 0x1 and req1 addr 0xE, held high -> req0 is served first (0x4C), then req1 (0xFF), then req0 again; grants alternate.
REQ-031 WAIT_STATES=0; req1 addr 0xF -> rom_sel high for one cycle; rsp1_valid two cycles after acceptance; rsp_data=0xF0.
REQ-032 rst asserted in the second ACCESS cycle of a req0 access -> rom_sel=0 and rsp_data=0x00 immediately; no rsp0_valid after release; the next contention goes to req0.
REQ-033 req0 addr changed from 0x0 to 0xE the cycle after acceptance -> response is still 0x4F.
REQ-034 Continuous random traffic on both ports -> each request gets exactly one response with the correct image byte; the REQ-026 invariants hold every cycle.
